// File: rtl/clcd_cmd_arbiter.sv
// N-channel command arbiter for the CLCD command path: one FIFO per channel, fixed-priority or
// round-robin selection, one command in flight on the downstream valid/busy port at a time.
module clcd_cmd_arbiter #(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MODE         = 0,
    parameter int unsigned BUSY_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic [N_CH-1:0]   i_valid,
    input  logic [8*N_CH-1:0] i_data,
    input  logic [N_CH-1:0]   i_RS,
    input  logic [N_CH-1:0]   i_RW,
    output logic [N_CH-1:0]   o_full,
    output logic [N_CH-1:0]   o_empty,
    output logic [N_CH-1:0]   o_ovf,
    output logic              o_valid,
    output logic [7:0]        o_data,
    output logic              o_RS,
    output logic              o_RW,
    input  logic              i_busy,
    output logic [N_CH-1:0]   o_grant,
    output logic              o_idle
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned WW = $clog2(N_CH);
    localparam int unsigned CW = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

    logic [PW-1:0] wr_ptr_q [N_CH];
    logic [PW-1:0] rd_ptr_q [N_CH];
    logic [9:0]    mem_q    [N_CH][DEPTH];
    logic [N_CH-1:0] full;
    logic [N_CH-1:0] empty;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [WW-1:0] rr_q;
    logic [WW-1:0] cand;
    logic [WW-1:0] win_idx;
    logic          win_found;
    logic          pop;
    logic [9:0]    head;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
            full[k]  = (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]) &&
                       (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]);
        end
    end

    assign o_full  = full;
    assign o_empty = empty;
    assign o_idle  = (&empty) && (state_q == StIdle);

    // Walk the search order backwards so the last hit is the first candidate in priority order.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned i = N_CH; i >= 1; i--) begin
            cand = (MODE == 0) ? WW'(i - 1) : WW'((32'(rr_q) + i) % N_CH);
            if (!empty[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign pop  = (state_q == StIdle) && win_found && !i_busy;
    assign head = mem_q[win_idx][rd_ptr_q[win_idx][AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset_p) begin
            for (int k = 0; k < N_CH; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
            o_ovf <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (i_valid[k]) begin
                    if (full[k]) begin
                        o_ovf[k] <= 1'b1;
                    end else begin
                        wr_ptr_q[k] <= wr_ptr_q[k] + PW'(1);
                    end
                end
                if (pop && (win_idx == WW'(k))) begin
                    rd_ptr_q[k] <= rd_ptr_q[k] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (i_valid[k] && !full[k]) begin
                mem_q[k][wr_ptr_q[k][AW-1:0]] <= {i_RS[k], i_RW[k], i_data[8*k +: 8]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rr_q    <= WW'(N_CH - 1);
            o_valid <= 1'b0;
            o_data  <= '0;
            o_RS    <= 1'b0;
            o_RW    <= 1'b0;
            o_grant <= '0;
        end else begin
            o_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        {o_RS, o_RW, o_data} <= head;
                        o_grant <= N_CH'(1) << win_idx;
                        if (MODE != 0) begin
                            rr_q <= win_idx;
                        end
                        o_valid <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWaitBusy;
                end
                StWaitBusy: begin
                    // A downstream that never raises busy must not wedge the queue.
                    if (i_busy) begin
                        state_q <= StWaitDone;
                    end else if (cnt_q == CW'(BUSY_TIMEOUT)) begin
                        state_q <= StIdle;
                        o_grant <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StWaitDone: begin
                    if (!i_busy) begin
                        state_q <= StIdle;
                        o_grant <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
